// File: rtl/tlb_refill_ctrl.sv
// Miss/refill sequencer for a fully-associative TLB: PLRU hit updates, page-walk
// requests, victim selection (first invalid entry, else PLRU) and entry refill.

module tlb_refill_ctrl_chk #(
  parameter int VPN_W = 27,
  parameter int IDX_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             req_valid,
  input logic             req_ready,
  input logic [VPN_W-1:0] req_vpn,
  input logic             wr_en,
  input logic [IDX_W-1:0] wr_idx,
  input logic             plru_hit,
  input logic [IDX_W-1:0] plru_idx,
  input logic             miss_err
);

  // A pending walk request must hold valid and its VPN until accepted.
  a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (req_valid && !req_ready) |=> (req_valid && $stable(req_vpn)));

  // Every refill write also marks the written entry most-recently-used.
  a_fill_touch : assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |-> (plru_hit && (plru_idx == wr_idx)));

  // Refill lasts exactly one cycle.
  a_fill_once : assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |=> !wr_en);

  // A faulted walk never coincides with a write.
  a_err_nowr : assert property (@(posedge clk) disable iff (!rst_n)
    miss_err |-> !wr_en);

endmodule

module tlb_refill_ctrl #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 27,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               lookup_valid_i,
  input  logic [VPN_W-1:0]   lookup_vpn_i,
  input  logic               lookup_hit_i,
  input  logic [IDX_W-1:0]   lookup_hit_idx_i,
  output logic               lookup_stall_o,
  input  logic [ENTRIES-1:0] entry_valid_i,
  output logic               ptw_req_valid_o,
  input  logic               ptw_req_ready_i,
  output logic [VPN_W-1:0]   ptw_req_vpn_o,
  input  logic               ptw_rsp_valid_i,
  input  logic               ptw_rsp_err_i,
  input  logic               flush_i,
  output logic               plru_en_o,
  output logic               plru_hit_o,
  output logic [IDX_W-1:0]   plru_idx_o,
  input  logic [IDX_W-1:0]   plru_repl_idx_i,
  output logic               wr_en_o,
  output logic [IDX_W-1:0]   wr_idx_o,
  output logic               miss_err_o,
  output logic [31:0]        miss_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } state_t;

  state_t             state_r;
  logic               kill_r;
  logic [VPN_W-1:0]   vpn_r;
  logic [IDX_W-1:0]   victim_r;
  logic [31:0]        miss_cnt_r;
  logic               miss_err_r;

  logic               is_idle_s;
  logic               idle_hit_s;
  logic               idle_miss_s;
  logic               fill_ok_s;
  logic               drop_s;
  logic [IDX_W:0]     free_s;
  logic [IDX_W-1:0]   victim_s;

  // {found, index} of the lowest-numbered invalid entry.
  function automatic logic [IDX_W:0] first_free(input logic [ENTRIES-1:0] valid);
    logic [IDX_W:0] res;
    res = {(IDX_W+1){1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        res = {1'b1, IDX_W'(i)};
      end
    end
    return res;
  endfunction

  assign is_idle_s   = (state_r == ST_IDLE);
  assign idle_hit_s  = is_idle_s & lookup_valid_i & lookup_hit_i & ~flush_i;
  assign idle_miss_s = is_idle_s & lookup_valid_i & ~lookup_hit_i & ~flush_i;
  assign fill_ok_s   = (state_r == ST_FILL) & ~flush_i;
  // A flush seen now or earlier in this walk makes its result stale.
  assign drop_s      = kill_r | flush_i;
  assign free_s      = first_free(entry_valid_i);
  assign victim_s    = free_s[IDX_W] ? free_s[IDX_W-1:0] : plru_repl_idx_i;

  // Sequencer state, latched request data, counter and error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      kill_r     <= 1'b0;
      vpn_r      <= {VPN_W{1'b0}};
      victim_r   <= {IDX_W{1'b0}};
      miss_cnt_r <= 32'd0;
      miss_err_r <= 1'b0;
    end else begin
      miss_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          kill_r <= 1'b0;
          if (idle_miss_s) begin
            vpn_r   <= lookup_vpn_i;
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush_i) begin
            kill_r <= 1'b1;
          end
          if (ptw_req_ready_i) begin
            if (miss_cnt_r != 32'hFFFF_FFFF) begin
              miss_cnt_r <= miss_cnt_r + 32'd1;
            end
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush_i) begin
            kill_r <= 1'b1;
          end
          if (ptw_rsp_valid_i) begin
            if (ptw_rsp_err_i || drop_s) begin
              miss_err_r <= ptw_rsp_err_i & ~drop_s;
              kill_r     <= 1'b0;
              state_r    <= ST_IDLE;
            end else begin
              victim_r <= victim_s;
              state_r  <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          kill_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          kill_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // PLRU access port: lookup hits in IDLE, the refilled entry in FILL.
  always_comb begin
    plru_hit_o = 1'b0;
    plru_idx_o = {IDX_W{1'b0}};
    if (idle_hit_s) begin
      plru_hit_o = 1'b1;
      plru_idx_o = lookup_hit_idx_i;
    end else if (fill_ok_s) begin
      plru_hit_o = 1'b1;
      plru_idx_o = victim_r;
    end else begin
      plru_hit_o = 1'b0;
      plru_idx_o = {IDX_W{1'b0}};
    end
  end

  assign lookup_stall_o  = ~is_idle_s | (lookup_valid_i & (~lookup_hit_i | flush_i));
  assign ptw_req_valid_o = (state_r == ST_REQ);
  assign ptw_req_vpn_o   = vpn_r;
  assign plru_en_o       = (state_r == ST_WAIT);
  assign wr_en_o         = fill_ok_s;
  assign wr_idx_o        = fill_ok_s ? victim_r : {IDX_W{1'b0}};
  assign miss_err_o      = miss_err_r;
  assign miss_cnt_o      = miss_cnt_r;

  tlb_refill_ctrl_chk #(
    .VPN_W (VPN_W),
    .IDX_W (IDX_W)
  ) u_chk (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .req_valid (ptw_req_valid_o),
    .req_ready (ptw_req_ready_i),
    .req_vpn   (ptw_req_vpn_o),
    .wr_en     (wr_en_o),
    .wr_idx    (wr_idx_o),
    .plru_hit  (plru_hit_o),
    .plru_idx  (plru_idx_o),
    .miss_err  (miss_err_o)
  );

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Self-checking bench for tlb_refill_ctrl: IDLE vector table, directed miss
// sequences, reset mid-walk, and a randomized run against a transaction model.
module tb_tlb_refill_ctrl;

  localparam int ENTRIES = 8;
  localparam int VPN_W   = 27;
  localparam int IDX_W   = 3;

  logic               clk;
  logic               rst_n;
  logic               lv;
  logic [VPN_W-1:0]   lvpn;
  logic               lhit;
  logic [IDX_W-1:0]   lidx;
  logic               stall;
  logic [ENTRIES-1:0] ev;
  logic               req_valid;
  logic               req_ready;
  logic [VPN_W-1:0]   req_vpn;
  logic               rsp_valid;
  logic               rsp_err;
  logic               flush;
  logic               plru_en;
  logic               plru_hit;
  logic [IDX_W-1:0]   plru_idx;
  logic [IDX_W-1:0]   repl;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               miss_err;
  logic [31:0]        miss_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_cnt;

  tlb_refill_ctrl #(.ENTRIES(ENTRIES), .VPN_W(VPN_W)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .lookup_valid_i   (lv),
    .lookup_vpn_i     (lvpn),
    .lookup_hit_i     (lhit),
    .lookup_hit_idx_i (lidx),
    .lookup_stall_o   (stall),
    .entry_valid_i    (ev),
    .ptw_req_valid_o  (req_valid),
    .ptw_req_ready_i  (req_ready),
    .ptw_req_vpn_o    (req_vpn),
    .ptw_rsp_valid_i  (rsp_valid),
    .ptw_rsp_err_i    (rsp_err),
    .flush_i          (flush),
    .plru_en_o        (plru_en),
    .plru_hit_o       (plru_hit),
    .plru_idx_o       (plru_idx),
    .plru_repl_idx_i  (repl),
    .wr_en_o          (wr_en),
    .wr_idx_o         (wr_idx),
    .miss_err_o       (miss_err),
    .miss_cnt_o       (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic       hit;
    logic [2:0] idx;
    logic       flush;
    logic       stall;
    logic       phit;
    logic [2:0] pidx;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    lv = 1'b0; lvpn = '0; lhit = 1'b0; lidx = '0; flush = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
    ev = 8'hFF; repl = 3'd0;
  endtask

  function automatic logic [2:0] pick(input logic [7:0] valid, input logic [2:0] plru);
    for (int i = 0; i < ENTRIES; i++) begin
      if (!valid[i]) return 3'(i);
    end
    return plru;
  endfunction

  // One full miss transaction with chosen latencies and flush/error placement.
  task automatic run_miss(input logic [VPN_W-1:0] vpn, input logic [7:0] valid,
                          input logic [2:0] plru, input int req_cyc, input int wait_cyc,
                          input logic err, input int flush_at, input logic flush_fill,
                          input logic [2:0] exp_idx);
    logic reach_fill;
    logic exp_err;
    reach_fill = !err && (flush_at < 0);
    exp_err    = err && (flush_at < 0);
    lv = 1'b1; lhit = 1'b0; lvpn = vpn; ev = valid; repl = plru;
    @(negedge clk);
    check("miss_stall", 32'(stall), 32'd1);
    check("miss_no_plru", 32'(plru_hit), 32'd0);
    tick();
    lv = 1'b0;
    for (int c = 0; c < req_cyc; c++) begin
      req_ready = (c == req_cyc - 1);
      @(negedge clk);
      check("req_valid", 32'(req_valid), 32'd1);
      check("req_vpn", 32'(req_vpn), 32'(vpn));
      check("req_stall", 32'(stall), 32'd1);
      tick();
    end
    req_ready = 1'b0;
    if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    for (int c = 0; c < wait_cyc; c++) begin
      rsp_valid = (c == wait_cyc - 1);
      rsp_err   = err;
      flush     = (c == flush_at);
      @(negedge clk);
      check("wait_plru_en", 32'(plru_en), 32'd1);
      check("wait_no_req", 32'(req_valid), 32'd0);
      check("wait_cnt", miss_cnt, exp_cnt);
      check("wait_no_wr", 32'(wr_en), 32'd0);
      tick();
    end
    rsp_valid = 1'b0; rsp_err = 1'b0; flush = 1'b0;
    if (reach_fill) begin
      flush = flush_fill;
      @(negedge clk);
      check("fill_wr_en", 32'(wr_en), 32'(!flush_fill));
      check("fill_plru_hit", 32'(plru_hit), 32'(!flush_fill));
      if (!flush_fill) begin
        check("fill_wr_idx", 32'(wr_idx), 32'(exp_idx));
        check("fill_plru_idx", 32'(plru_idx), 32'(exp_idx));
      end
      tick();
      flush = 1'b0;
    end
    @(negedge clk);
    check("post_err", 32'(miss_err), 32'(exp_err));
    check("post_wr", 32'(wr_en), 32'd0);
    check("post_plru_hit", 32'(plru_hit), 32'd0);
    check("post_idle_stall", 32'(stall), 32'd0);
    check("post_idle_req", 32'(req_valid), 32'd0);
    tick();
    @(negedge clk);
    check("err_single", 32'(miss_err), 32'd0);
    tick();
  endtask

  // Transaction-level reference state for the randomized run.
  bit          m_pending, m_accepted, m_fill, m_kill, m_errp, m_errn, m_drop;
  logic [VPN_W-1:0] m_vpn;
  logic [2:0]  m_victim;
  logic        e_stall, e_req, e_phit, e_wr, ihit, fok;
  logic [2:0]  e_pidx;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 3'd5};
    vecs[2] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[3] = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 3'd7};
    vecs[4] = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[5] = '{1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[6] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[7] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0};

    quiet();
    rst_n = 1'b0;
    exp_cnt = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(req_valid), 32'd0);
    check("rst_cnt", miss_cnt, 32'd0);
    check("rst_wr", 32'(wr_en), 32'd0);
    check("rst_err", 32'(miss_err), 32'd0);
    check("rst_plru_en", 32'(plru_en), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      lv = vecs[i].lv; lhit = vecs[i].hit; lidx = vecs[i].idx; flush = vecs[i].flush;
      lvpn = 27'h7;
      @(negedge clk);
      check("vec_stall", 32'(stall), 32'(vecs[i].stall));
      check("vec_plru_hit", 32'(plru_hit), 32'(vecs[i].phit));
      check("vec_plru_idx", 32'(plru_idx), 32'(vecs[i].pidx));
      check("vec_no_wr", 32'(wr_en), 32'd0);
      tick();
      quiet();
      @(negedge clk);
      check("vec_no_req", 32'(req_valid), 32'd0);
      tick();
    end

    run_miss(27'h123,  8'hFF,        3'd3, 3, 4, 1'b0, -1, 1'b0, 3'd3);
    check("cnt_after_first", miss_cnt, 32'd1);
    run_miss(27'h4567, 8'b1111_0101, 3'd6, 1, 1, 1'b0, -1, 1'b0, 3'd1);
    run_miss(27'h1,    8'h7F,        3'd2, 2, 2, 1'b0, -1, 1'b0, 3'd7);
    run_miss(27'h2AB,  8'hFF,        3'd4, 1, 4, 1'b0,  1, 1'b0, 3'd0);
    run_miss(27'h2AC,  8'hFF,        3'd4, 1, 2, 1'b0, -1, 1'b0, 3'd4);
    run_miss(27'h3FF,  8'h00,        3'd1, 2, 3, 1'b1, -1, 1'b0, 3'd0);
    run_miss(27'h55,   8'hFE,        3'd5, 1, 1, 1'b0, -1, 1'b1, 3'd0);
    run_miss(27'h66,   8'hFF,        3'd2, 1, 2, 1'b1,  1, 1'b0, 3'd0);

    // Reset while the walk request is outstanding.
    lv = 1'b1; lhit = 1'b0; lvpn = 27'hABC;
    tick();
    quiet();
    @(negedge clk);
    check("pre_rst_req", 32'(req_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(req_valid), 32'd0);
    check("async_rst_cnt", miss_cnt, 32'd0);
    tick();
    rsp_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rsp_valid = 1'b0;
    @(negedge clk);
    check("rst_rsp_ignored_wr", 32'(wr_en), 32'd0);
    check("rst_rsp_ignored_req", 32'(req_valid), 32'd0);
    check("rst_rsp_ignored_en", 32'(plru_en), 32'd0);
    tick();
    exp_cnt = 32'd0;

    m_pending = 0; m_accepted = 0; m_fill = 0; m_kill = 0; m_errp = 0;
    m_vpn = '0; m_victim = '0;
    for (int n = 0; n < 600; n++) begin
      lv        = ($urandom_range(0, 1) == 0);
      lhit      = ($urandom_range(0, 1) == 0);
      lidx      = 3'($urandom);
      lvpn      = 27'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      req_ready = ($urandom_range(0, 1) == 0);
      rsp_valid = ($urandom_range(0, 2) == 0);
      rsp_err   = ($urandom_range(0, 3) == 0);
      ev        = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      repl      = 3'($urandom);
      @(negedge clk);
      ihit    = !m_pending && lv && lhit && !flush;
      fok     = m_fill && !flush;
      e_stall = m_pending || (lv && (!lhit || flush));
      e_req   = m_pending && !m_accepted && !m_fill;
      e_phit  = ihit || fok;
      e_pidx  = ihit ? lidx : (fok ? m_victim : 3'd0);
      e_wr    = fok;
      check("rnd_stall", 32'(stall), 32'(e_stall));
      check("rnd_req", 32'(req_valid), 32'(e_req));
      if (e_req) check("rnd_req_vpn", 32'(req_vpn), 32'(m_vpn));
      check("rnd_plru_en", 32'(plru_en), 32'(m_accepted));
      check("rnd_plru_hit", 32'(plru_hit), 32'(e_phit));
      check("rnd_plru_idx", 32'(plru_idx), 32'(e_pidx));
      check("rnd_wr_en", 32'(wr_en), 32'(e_wr));
      if (e_wr) check("rnd_wr_idx", 32'(wr_idx), 32'(m_victim));
      check("rnd_err", 32'(miss_err), 32'(m_errp));
      check("rnd_cnt", miss_cnt, exp_cnt);
      m_errn = 0;
      if (!m_pending) begin
        m_kill = 0;
        if (lv && !lhit && !flush) begin
          m_pending = 1;
          m_vpn = lvpn;
        end
      end else if (m_fill) begin
        m_fill = 0; m_pending = 0; m_kill = 0;
      end else if (!m_accepted) begin
        if (flush) m_kill = 1;
        if (req_ready) begin
          m_accepted = 1;
          if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        end
      end else begin
        m_drop = m_kill || flush;
        if (flush) m_kill = 1;
        if (rsp_valid) begin
          m_accepted = 0;
          if (rsp_err || m_drop) begin
            m_pending = 0; m_kill = 0;
            m_errn = rsp_err && !m_drop;
          end else begin
            m_fill = 1;
            m_victim = pick(ev, repl);
          end
        end
      end
      m_errp = m_errn;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
